// File: rtl/axi_single_beat_master_if.sv
// AXI4 channel bundle (AW/W/B/AR/R) between a single-beat initiator and its slave.
// The master modport is the initiator's view and the slave modport is the responder's view.
interface axi_single_beat_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_single_beat_master.sv
// Single-outstanding AXI4 initiator turning command/response requests into one-beat INCR transfers.
// Define AXI_MASTER_ID_CHECK_EN to flag B/R ID mismatches as SLVERR and expose a sticky id_err port.
module axi_single_beat_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [ID_WIDTH-1:0]   rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [15:0]           rsp_latency,
`ifdef AXI_MASTER_ID_CHECK_EN
  output logic                  id_err,
`endif
  axi_single_beat_master_if.master axi
);

  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t                state, state_next;
  logic                  write_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [15:0]           lat_q, lat_inc;

  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs, beat_hs;
  logic [ID_WIDTH-1:0] beat_id;
  logic [1:0]          beat_resp;
  logic cmd_ready_d, awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, rsp_valid_d;
  logic unused_rlast;
`ifdef AXI_MASTER_ID_CHECK_EN
  logic id_bad;
`endif

  // Single beat per burst, so rlast carries no information.
  assign unused_rlast = axi.rlast;

  assign axi.awid    = id_q;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'($clog2(STRB_WIDTH));
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 1'b0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.arid    = id_q;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'($clog2(STRB_WIDTH));
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 1'b0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;

  // Each valid/ready drops on its own handshake; the FSM only raises them on entry to a state.
  always_comb begin
    accept    = cmd_valid && cmd_ready;
    aw_hs     = axi.awvalid && axi.awready;
    w_hs      = axi.wvalid && axi.wready;
    b_hs      = axi.bvalid && axi.bready;
    ar_hs     = axi.arvalid && axi.arready;
    r_hs      = axi.rvalid && axi.rready;
    rsp_hs    = rsp_valid && rsp_ready;
    beat_hs   = b_hs || r_hs;
    lat_inc   = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;
    beat_id   = b_hs ? axi.bid : axi.rid;
    beat_resp = b_hs ? axi.bresp : axi.rresp;
`ifdef AXI_MASTER_ID_CHECK_EN
    id_bad    = beat_hs && (beat_id != id_q);
    if (id_bad) beat_resp = 2'b10;
`endif
    state_next  = state;
    cmd_ready_d = cmd_ready;
    awvalid_d   = axi.awvalid && !aw_hs;
    wvalid_d    = axi.wvalid && !w_hs;
    bready_d    = axi.bready && !b_hs;
    arvalid_d   = axi.arvalid && !ar_hs;
    rready_d    = axi.rready && !r_hs;
    rsp_valid_d = rsp_valid && !rsp_hs;
    case (state)
      IDLE: if (accept) begin
        cmd_ready_d = 1'b0;
        if (cmd_write) begin
          state_next = WR_ADDR_DATA;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
        end else begin
          state_next = RD_ADDR;
          arvalid_d  = 1'b1;
        end
      end
      WR_ADDR_DATA: if ((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready)) begin
        state_next = WR_RESP;
        bready_d   = 1'b1;
      end
      WR_RESP: if (b_hs) begin
        state_next  = RSP;
        rsp_valid_d = 1'b1;
      end
      RD_ADDR: if (ar_hs) begin
        state_next = RD_DATA;
        rready_d   = 1'b1;
      end
      RD_DATA: if (r_hs) begin
        state_next  = RSP;
        rsp_valid_d = 1'b1;
      end
      RSP: if (rsp_hs) begin
        state_next  = IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_next  = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // Latency counts every cycle spent waiting on the slave, including the B/R handshake cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      rsp_valid   <= 1'b0;
      write_q     <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      lat_q       <= '0;
      rsp_write   <= 1'b0;
      rsp_id      <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_latency <= '0;
`ifdef AXI_MASTER_ID_CHECK_EN
      id_err      <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      cmd_ready   <= cmd_ready_d;
      axi.awvalid <= awvalid_d;
      axi.wvalid  <= wvalid_d;
      axi.bready  <= bready_d;
      axi.arvalid <= arvalid_d;
      axi.rready  <= rready_d;
      rsp_valid   <= rsp_valid_d;
      if (accept) begin
        write_q <= cmd_write;
        id_q    <= cmd_id;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        lat_q   <= '0;
      end else if (state != IDLE && state != RSP) begin
        lat_q <= lat_inc;
      end
      if (beat_hs) begin
        rsp_write   <= write_q;
        rsp_id      <= beat_id;
        rsp_rdata   <= b_hs ? '0 : axi.rdata;
        rsp_resp    <= beat_resp;
        rsp_latency <= lat_inc;
      end
`ifdef AXI_MASTER_ID_CHECK_EN
      if (id_bad) id_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_axi_single_beat_master.sv
// Self-checking bench: a delay-configurable AXI slave with memory plus a reference model of
// expected response fields (latency from slave delays, read data from a byte-merged memory).
module tb_axi_single_beat_master;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_id;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [7:0]  rsp_id;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_latency;
`ifdef AXI_MASTER_ID_CHECK_EN
  logic        id_err;
`endif

  int checks = 0;
  int errors = 0;

  int aw_dly, w_dly, ar_dly, b_dly, r_dly;
  logic [1:0] b_resp_cfg, r_resp_cfg;
  logic [7:0] id_xor;

  bit          aw_seen = 0, w_seen = 0, b_pend = 0, r_pend = 0;
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_cnt = 0, r_cnt = 0;
  logic [7:0]  s_aw_id = '0, s_ar_id = '0;
  logic [15:0] s_aw_addr = '0;
  logic [31:0] s_wdata = '0, s_rdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic [31:0] slave_mem [int];
  logic [31:0] ref_mem [int];

  axi_single_beat_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) axi ();

  axi_single_beat_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_id      (cmd_id),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_write   (rsp_write),
    .rsp_id      (rsp_id),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_latency (rsp_latency),
`ifdef AXI_MASTER_ID_CHECK_EN
    .id_err      (id_err),
`endif
    .axi         (axi.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] res = old;
    for (int i = 0; i < 4; i++) if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    return res;
  endfunction

  // Slave bookkeeping on the clock edge; values read here are the pre-edge ones.
  always @(posedge clock) begin
    if (reset) begin
      aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      if (b_pend) begin
        if (axi.bvalid && axi.bready) b_pend = 0; else b_cnt++;
      end
      if (r_pend) begin
        if (axi.rvalid && axi.rready) r_pend = 0; else r_cnt++;
      end
      if (axi.awvalid) begin
        if (axi.awready) begin aw_seen = 1; s_aw_id = axi.awid; s_aw_addr = axi.awaddr; aw_wait = 0; end
        else aw_wait++;
      end
      if (axi.wvalid) begin
        if (axi.wready) begin w_seen = 1; s_wdata = axi.wdata; s_wstrb = axi.wstrb; w_wait = 0; end
        else w_wait++;
      end
      if (aw_seen && w_seen) begin
        slave_mem[int'(s_aw_addr >> 2)] = merge(slave_mem.exists(int'(s_aw_addr >> 2)) ? slave_mem[int'(s_aw_addr >> 2)] : 32'h0, s_wdata, s_wstrb);
        aw_seen = 0; w_seen = 0; b_pend = 1; b_cnt = 0;
      end
      if (axi.arvalid) begin
        if (axi.arready) begin
          s_ar_id = axi.arid;
          s_rdata = slave_mem.exists(int'(axi.araddr >> 2)) ? slave_mem[int'(axi.araddr >> 2)] : 32'h0;
          r_pend = 1; r_cnt = 0; ar_wait = 0;
        end else ar_wait++;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      axi.awready = 0; axi.wready = 0; axi.arready = 0; axi.bvalid = 0; axi.rvalid = 0;
      axi.bid = '0; axi.bresp = '0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0;
    end else begin
      axi.awready = axi.awvalid && (aw_wait >= aw_dly);
      axi.wready  = axi.wvalid && (w_wait >= w_dly);
      axi.arready = axi.arvalid && (ar_wait >= ar_dly);
      axi.bvalid  = b_pend && (b_cnt >= b_dly);
      axi.bid     = s_aw_id ^ id_xor;
      axi.bresp   = b_resp_cfg;
      axi.rvalid  = r_pend && (r_cnt >= r_dly);
      axi.rid     = s_ar_id ^ id_xor;
      axi.rdata   = s_rdata;
      axi.rresp   = r_resp_cfg;
      axi.rlast   = 1'b1;
    end
  end

  task automatic set_slave(input int aw, input int w, input int ar, input int b, input int r,
                           input logic [1:0] bresp_c, input logic [1:0] rresp_c, input logic [7:0] idx);
    aw_dly = aw; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
    b_resp_cfg = bresp_c; r_resp_cfg = rresp_c; id_xor = idx;
  endtask

  task automatic model_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
    ref_mem[int'(addr >> 2)] = merge(ref_mem.exists(int'(addr >> 2)) ? ref_mem[int'(addr >> 2)] : 32'h0, data, strb);
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] addr);
    return ref_mem.exists(int'(addr >> 2)) ? ref_mem[int'(addr >> 2)] : 32'h0;
  endfunction

  // Called on a falling edge; returns on the falling edge of the cycle after the accept.
  task automatic send_cmd(input logic wr, input logic [7:0] id, input logic [15:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    while (!cmd_ready && n < 20) begin @(negedge clock); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("[TB] FAIL cmd_accept_timeout got=%b exp=1", cmd_ready);
    end
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, output logic got_wr, output logic [7:0] got_id,
                          output logic [31:0] got_data, output logic [1:0] got_resp, output logic [15:0] got_lat);
    int n = 0;
    while (!rsp_valid && n < 300) begin @(negedge clock); n++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("[TB] FAIL rsp_timeout got=%b exp=1", rsp_valid);
    end
    got_wr = rsp_write; got_id = rsp_id; got_data = rsp_rdata; got_resp = rsp_resp; got_lat = rsp_latency;
    repeat (hold) @(negedge clock);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if ({rsp_valid, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_valids got=%b exp=000000", {rsp_valid, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready});
    end
    checks++; if ({rsp_write, rsp_id, rsp_rdata, rsp_resp, rsp_latency} !== 59'd0) begin
      errors++; $display("[TB] FAIL reset_rsp_fields got=%h exp=0", {rsp_write, rsp_id, rsp_rdata, rsp_resp, rsp_latency});
    end
    checks++; if ({axi.awaddr, axi.awid, axi.wdata, axi.wstrb, axi.araddr, axi.arid} !== 84'd0) begin
      errors++; $display("[TB] FAIL reset_axi_fields got=%h exp=0", {axi.awaddr, axi.awid, axi.wdata, axi.wstrb, axi.araddr, axi.arid});
    end
`ifdef AXI_MASTER_ID_CHECK_EN
    checks++; if (id_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_err got=%b exp=0", id_err); end
`endif
    reset = 1'b0;
    @(negedge clock);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_min_write();
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 8'h00);
    send_cmd(1'b1, 8'h00, 16'h0000, 32'h00010001, 4'hF);
    model_write(16'h0000, 32'h00010001, 4'hF);
    checks++; if ({axi.awvalid, axi.wvalid, cmd_ready} !== 3'b110) begin
      errors++; $display("[TB] FAIL wr_cycle1 got=%b exp=110", {axi.awvalid, axi.wvalid, cmd_ready});
    end
    checks++; if ({axi.awlen, axi.awsize, axi.awburst, axi.wlast, axi.awaddr, axi.wdata, axi.wstrb} !== {8'd0, 3'd2, 2'b01, 1'b1, 16'h0000, 32'h00010001, 4'hF}) begin
      errors++; $display("[TB] FAIL wr_aw_fields got=%h", {axi.awlen, axi.awsize, axi.awburst, axi.wlast, axi.awaddr, axi.wdata, axi.wstrb});
    end
    @(negedge clock);
    checks++; if ({axi.awvalid, axi.wvalid, axi.bready, rsp_valid} !== 4'b0010) begin
      errors++; $display("[TB] FAIL wr_cycle2 got=%b exp=0010", {axi.awvalid, axi.wvalid, axi.bready, rsp_valid});
    end
    @(negedge clock);
    checks++; if ({rsp_valid, axi.bready, rsp_write, rsp_resp, rsp_latency, rsp_rdata} !== {1'b1, 1'b0, 1'b1, 2'b00, 16'd2, 32'h0}) begin
      errors++; $display("[TB] FAIL wr_cycle3_rsp got=%b/%b/%b resp=%0d lat=%0d exp=1/0/1 resp=0 lat=2", rsp_valid, axi.bready, rsp_write, rsp_resp, rsp_latency);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("[TB] FAIL wr_back_idle got=%b exp=10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_min_read();
    logic wr; logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic [15:0] lat;
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 8'h00);
    send_cmd(1'b0, 8'h01, 16'h0000, 32'h0, 4'h0);
    checks++; if ({axi.arvalid, axi.arlen, axi.arsize, axi.arburst, axi.arid} !== {1'b1, 8'd0, 3'd2, 2'b01, 8'h01}) begin
      errors++; $display("[TB] FAIL rd_cycle1 got=%h", {axi.arvalid, axi.arlen, axi.arsize, axi.arburst, axi.arid});
    end
    @(negedge clock);
    checks++; if ({axi.arvalid, axi.rready} !== 2'b01) begin
      errors++; $display("[TB] FAIL rd_cycle2 got=%b exp=01", {axi.arvalid, axi.rready});
    end
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rd_cycle3_valid got=%b exp=1", rsp_valid); end
    wait_rsp(0, wr, id, data, resp, lat);
    checks++; if ({wr, id, data, resp, lat} !== {1'b0, 8'h01, model_read(16'h0000), 2'b00, 16'd2}) begin
      errors++; $display("[TB] FAIL rd_rsp got=%b/%h/%h/%0d/%0d exp=0/01/%h/0/2", wr, id, data, resp, lat, model_read(16'h0000));
    end
  endtask

  task automatic test_aw_delay();
    logic wr; logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic [15:0] lat;
    set_slave(3, 0, 0, 0, 0, 2'b00, 2'b00, 8'h00);
    send_cmd(1'b1, 8'h05, 16'h0010, 32'hCAFE1234, 4'hF);
    model_write(16'h0010, 32'hCAFE1234, 4'hF);
    checks++; if ({axi.awvalid, axi.wvalid} !== 2'b11) begin
      errors++; $display("[TB] FAIL awd_cycle1 got=%b exp=11", {axi.awvalid, axi.wvalid});
    end
    for (int c = 2; c <= 4; c++) begin
      @(negedge clock);
      checks++; if ({axi.awvalid, axi.wvalid, axi.awaddr, axi.bready} !== {1'b1, 1'b0, 16'h0010, 1'b0}) begin
        errors++; $display("[TB] FAIL awd_hold_c%0d got=%b/%b/%h/%b exp=1/0/0010/0", c, axi.awvalid, axi.wvalid, axi.awaddr, axi.bready);
      end
    end
    @(negedge clock);
    checks++; if ({axi.awvalid, axi.bready} !== 2'b01) begin
      errors++; $display("[TB] FAIL awd_cycle5 got=%b exp=01", {axi.awvalid, axi.bready});
    end
    wait_rsp(0, wr, id, data, resp, lat);
    checks++; if (lat !== 16'd5) begin errors++; $display("[TB] FAIL awd_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_rsp_hold();
    int n = 0;
    set_slave(0, 0, 0, 1, 0, 2'b01, 2'b00, 8'h00);
    send_cmd(1'b1, 8'h3C, 16'h0008, 32'h55AA55AA, 4'h5);
    model_write(16'h0008, 32'h55AA55AA, 4'h5);
    while (!rsp_valid && n < 20) begin @(negedge clock); n++; end
    for (int c = 0; c < 5; c++) begin
      checks++; if ({rsp_valid, cmd_ready, rsp_write, rsp_id, rsp_resp, rsp_latency, rsp_rdata} !== {1'b1, 1'b0, 1'b1, 8'h3C, 2'b01, 16'd3, 32'h0}) begin
        errors++; $display("[TB] FAIL hold_c%0d got=%b/%b/%b/%h/%0d/%0d exp=1/0/1/3c/1/3", c, rsp_valid, cmd_ready, rsp_write, rsp_id, rsp_resp, rsp_latency);
      end
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++; $display("[TB] FAIL hold_release got=%b exp=01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_random();
    logic wr; logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic [15:0] lat;
    logic c_wr; logic [7:0] c_id; logic [15:0] c_addr; logic [31:0] c_data; logic [3:0] c_strb;
    int aw, w, ar, b, r;
    logic [1:0] br, rr;
    logic [31:0] exp_data; logic [1:0] exp_resp; int exp_lat;
    for (int t = 0; t < 40; t++) begin
      aw = $urandom_range(0, 3); w = $urandom_range(0, 3); ar = $urandom_range(0, 3);
      b = $urandom_range(0, 3); r = $urandom_range(0, 3);
      br = 2'($urandom_range(0, 3)); rr = 2'($urandom_range(0, 3));
      set_slave(aw, w, ar, b, r, br, rr, 8'h00);
      c_wr = 1'($urandom_range(0, 1)); c_id = 8'($urandom); c_addr = 16'($urandom_range(0, 7) * 4);
      c_data = $urandom; c_strb = 4'($urandom);
      send_cmd(c_wr, c_id, c_addr, c_data, c_strb);
      if (c_wr) begin
        model_write(c_addr, c_data, c_strb);
        exp_data = 32'h0; exp_resp = br; exp_lat = ((aw > w) ? aw : w) + 2 + b;
      end else begin
        exp_data = model_read(c_addr); exp_resp = rr; exp_lat = ar + 2 + r;
      end
      wait_rsp($urandom_range(0, 2), wr, id, data, resp, lat);
      checks++; if ({wr, id, resp} !== {c_wr, c_id, exp_resp}) begin
        errors++; $display("[TB] FAIL rand%0d_hdr got=%b/%h/%0d exp=%b/%h/%0d", t, wr, id, resp, c_wr, c_id, exp_resp);
      end
      checks++; if (data !== exp_data) begin
        errors++; $display("[TB] FAIL rand%0d_data got=%h exp=%h", t, data, exp_data);
      end
      checks++; if (lat !== 16'(exp_lat)) begin
        errors++; $display("[TB] FAIL rand%0d_latency got=%0d exp=%0d", t, lat, exp_lat);
      end
    end
`ifdef AXI_MASTER_ID_CHECK_EN
    checks++; if (id_err !== 1'b0) begin errors++; $display("[TB] FAIL rand_id_err got=%b exp=0", id_err); end
`endif
  endtask

  task automatic test_id_check();
    logic wr; logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic [15:0] lat;
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b01, 8'h04);
    send_cmd(1'b0, 8'h03, 16'h0000, 32'h0, 4'h0);
    wait_rsp(0, wr, id, data, resp, lat);
    checks++; if (id !== 8'h07) begin errors++; $display("[TB] FAIL idc_rsp_id got=%h exp=07", id); end
`ifdef AXI_MASTER_ID_CHECK_EN
    checks++; if ({resp, id_err} !== {2'b10, 1'b1}) begin
      errors++; $display("[TB] FAIL idc_mismatch got=resp %0d id_err %b exp=resp 2 id_err 1", resp, id_err);
    end
`else
    checks++; if (resp !== 2'b01) begin errors++; $display("[TB] FAIL idc_passthru got=%0d exp=1", resp); end
`endif
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 8'h00);
    send_cmd(1'b1, 8'h09, 16'h0004, 32'h12345678, 4'hF);
    model_write(16'h0004, 32'h12345678, 4'hF);
    wait_rsp(0, wr, id, data, resp, lat);
    checks++; if ({id, resp} !== {8'h09, 2'b00}) begin
      errors++; $display("[TB] FAIL idc_clean got=%h/%0d exp=09/0", id, resp);
    end
`ifdef AXI_MASTER_ID_CHECK_EN
    checks++; if (id_err !== 1'b1) begin errors++; $display("[TB] FAIL idc_sticky got=%b exp=1", id_err); end
`endif
  endtask

  task automatic test_reset_mid();
    logic wr; logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic [15:0] lat;
    int n = 0;
    set_slave(0, 0, 0, 0, 20, 2'b00, 2'b00, 8'h00);
    send_cmd(1'b0, 8'h44, 16'h0004, 32'h0, 4'h0);
    while (!axi.rready && n < 10) begin @(negedge clock); n++; end
    checks++; if (axi.rready !== 1'b1) begin errors++; $display("[TB] FAIL rstm_reach_rd_data got=%b exp=1", axi.rready); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({axi.arvalid, axi.rready, rsp_valid, cmd_ready} !== 4'b0001) begin
      errors++; $display("[TB] FAIL rstm_async got=%b exp=0001", {axi.arvalid, axi.rready, rsp_valid, cmd_ready});
    end
    @(negedge clock);
    reset = 1'b0;
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 8'h00);
    @(negedge clock);
    send_cmd(1'b1, 8'h2A, 16'h0020, 32'hA5A5F00D, 4'hF);
    model_write(16'h0020, 32'hA5A5F00D, 4'hF);
    wait_rsp(0, wr, id, data, resp, lat);
    checks++; if ({wr, id, resp, lat} !== {1'b1, 8'h2A, 2'b00, 16'd2}) begin
      errors++; $display("[TB] FAIL rstm_write got=%b/%h/%0d/%0d exp=1/2a/0/2", wr, id, resp, lat);
    end
    send_cmd(1'b0, 8'h2B, 16'h0020, 32'h0, 4'h0);
    wait_rsp(0, wr, id, data, resp, lat);
    checks++; if (data !== model_read(16'h0020)) begin
      errors++; $display("[TB] FAIL rstm_readback got=%h exp=%h", data, model_read(16'h0020));
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 8'h00);
    test_reset();
    test_min_write();
    test_min_read();
    test_aw_delay();
    test_rsp_hold();
    test_random();
    test_id_check();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_single_beat_master.md
# axi_single_beat_master

Synthesizable AXI4 initiator that turns simple command/response requests into single-beat (AWLEN/ARLEN = 0, INCR) AXI4 write and read transactions. It sits between a local controller (sequencer, DMA front end, or bus bridge) and an AXI4 slave such as `axi_top_16x16`. Only one transaction is outstanding at a time. Each completed transaction returns its data, response code and measured latency.

## Interface
- DATA_WIDTH, 32, AXI data width
- ADDR_WIDTH, 16, AXI address width
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width
- ID_WIDTH, 8, AXI ID width
- clock  in  1  single clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_id  in  ID_WIDTH  transaction ID
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  STRB_WIDTH  write strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write, rsp_id, rsp_rdata, rsp_resp  out  1/ID_WIDTH/DATA_WIDTH/2  type, ID, read data (0 for writes), BRESP/RRESP
- rsp_latency  out  16  cycles from command accept to B/R handshake, saturating at 0xFFFF
- id_err  out  1  sticky ID-mismatch flag (present only with the macro)
- m_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid}  out, m_axi_awready  in
- m_axi_w{data,strb,last,valid}  out, m_axi_wready  in
- m_axi_b{id,resp,valid}  in, m_axi_bready  out
- m_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}  out, m_axi_arready  in
- m_axi_r{id,data,resp,last,valid}  in, m_axi_rready  out

## Operation
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready = 1. On accept, latch the command and go to WR_ADDR_DATA (write) or RD_ADDR (read).
- WR_ADDR_DATA: assert awvalid and wvalid together. Each drops independently on its own handshake. Leave the state when both handshakes are done, including the same-cycle case. Next state: WR_RESP.
- WR_RESP: bready = 1. On bvalid, capture bid and bresp. Next state: RSP.
- RD_ADDR: arvalid = 1 until arready. Next state: RD_DATA.
- RD_DATA: rready = 1. On rvalid, capture rid, rdata and rresp. Next state: RSP.
  - rlast is ignored, because the burst has one beat.
- RSP: rsp_valid = 1, with all rsp_* fields held stable until rsp_ready. Then return to IDLE.
- Constant fields:
  - len = 0, size = $clog2(STRB_WIDTH), burst = 2'b01, lock = 0, cache = 0, prot = 0, wlast = 1.
  - awid/arid = cmd_id; addr, data and strb come from the latched command.
- Latency counter:
  - Clears on command accept.
  - Increments each cycle in every non-IDLE, non-RSP state, saturating at 0xFFFF.
  - Its value is frozen into rsp_latency on the B/R handshake.

## Timing
- All outputs are registered.
- Reset values:
  - All valid/ready outputs are 0, except cmd_ready, which is 1 (IDLE).
  - All rsp_* fields, all m_axi address/data/id fields, and id_err are 0.
- Minimum write latency (slave always ready): accept at cycle 0; AW and W handshake at cycle 1; B handshake at cycle 2; rsp_valid at cycle 3; rsp_latency = 2.
- Minimum read latency is the same: AR at cycle 1, R at cycle 2, rsp_valid at cycle 3.
- AXI stability: once a valid is asserted, that channel's payload stays constant until its handshake. A valid is never withdrawn before its handshake.
- cmd_ready is 0 in every state except IDLE. There is no command/response overlap.
- Reset mid-transaction: the FSM returns to IDLE and all valids drop asynchronously. The slave must be reset by the same reset.

## Configuration
- AXI_MASTER_ID_CHECK_EN
  - Defined: compare bid/rid against the latched ID at the handshake. On mismatch, force rsp_resp = 2'b10 (SLVERR) and set id_err. id_err stays set until reset.
  - Undefined: no comparison; rsp_resp is passed through unchanged; the id_err port is absent.

## Test plan
- Write 0x00010001 to address 0x0000 with ID 0, slave always ready -> AW and W at cycle 1, bready at cycle 2, rsp_valid at cycle 3 with rsp_resp = 0 and rsp_latency = 2.
- Read address 0x0000 with ID 1 after that write -> rsp_rdata = 0x00010001, rsp_id = 1, rsp_write = 0, rsp_resp = 0.
- Write with awready delayed 3 cycles and wready immediate -> wvalid drops after cycle 1, awvalid stays high with a stable address until cycle 4, rsp_latency = 5.
- Hold rsp_ready low for 5 cycles -> rsp_* fields stable and cmd_ready = 0 throughout; return to IDLE one cycle after rsp_ready.
- With AXI_MASTER_ID_CHECK_EN, slave returns rid = 7 for arid = 3 -> rsp_resp = 2'b10 and id_err = 1; id_err still 1 after a subsequent clean transaction.
- Assert reset while in RD_DATA -> arvalid/rready = 0 and cmd_ready = 1 immediately; a following write completes normally.
